// File: rtl/mem_access_if.sv
// mem_access_if -- bundle of every non-clock/reset signal of the memory
// access stage.
//
//   Execute side : ex_valid, ex_ready, ex_is_load, ex_is_store, ex_addr,
//                  ex_store_data, ex_dest_reg
//   Memory side  : data_addr, data_out, data_read, data_write, data_in,
//                  mem_ack
//   Writeback    : wb_valid, wb_we, wb_dest_reg, wb_data
//   Error report : fault, fault_code (01 misaligned, 10 illegal, 11 timeout)
//
// The slave modport is the stage itself; the master modport is everything
// around it (execute stage, data memory and writeback consumer).
interface mem_access_if;
   logic        ex_valid;
   logic        ex_ready;
   logic        ex_is_load;
   logic        ex_is_store;
   logic [31:0] ex_addr;
   logic [31:0] ex_store_data;
   logic [3:0]  ex_dest_reg;

   logic [31:0] data_addr;
   logic [31:0] data_out;
   logic        data_read;
   logic        data_write;
   logic [31:0] data_in;
   logic        mem_ack;

   logic        wb_valid;
   logic        wb_we;
   logic [3:0]  wb_dest_reg;
   logic [31:0] wb_data;

   logic        fault;
   logic [1:0]  fault_code;

   modport slave (
      input  ex_valid, ex_is_load, ex_is_store, ex_addr, ex_store_data,
             ex_dest_reg, data_in, mem_ack,
      output ex_ready, data_addr, data_out, data_read, data_write,
             wb_valid, wb_we, wb_dest_reg, wb_data, fault, fault_code
   );

   modport master (
      output ex_valid, ex_is_load, ex_is_store, ex_addr, ex_store_data,
             ex_dest_reg, data_in, mem_ack,
      input  ex_ready, data_addr, data_out, data_read, data_write,
             wb_valid, wb_we, wb_dest_reg, wb_data, fault, fault_code
   );
endinterface

// File: rtl/mem_access.sv
// mem_access -- memory access pipeline stage.
//
// Accepts one operation from the execute stage when ex_valid && ex_ready.
// Non-memory operations are forwarded to writeback the next cycle.
// Aligned loads/stores run a strobe on the data memory until mem_ack or a
// timeout, then produce one writeback cycle. Misaligned or illegal
// (load+store) operations never touch memory and report a fault instead.
//
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-high reset
//   bus    : mem_access_if.slave (execute, data memory, writeback, fault)
//
// Parameter:
//   TIMEOUT : access cycles without mem_ack before the access is aborted
//             (counter is 4 bits, so 1..16).
module mem_access #(
   parameter int unsigned TIMEOUT = 16
) (
   input logic          clk,
   input logic          reset,
   mem_access_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   // Last count value before an unacknowledged access is abandoned.
   localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

   localparam logic [1:0] CODE_MISALIGN = 2'b01;
   localparam logic [1:0] CODE_ILLEGAL  = 2'b10;
   localparam logic [1:0] CODE_TIMEOUT  = 2'b11;

   state_t      state_q;
   logic [3:0]  cnt_q;

   logic [31:0] data_addr_q;
   logic [31:0] data_out_q;
   logic        data_read_q;
   logic        data_write_q;
   logic        wb_valid_q;
   logic        wb_we_q;
   logic [3:0]  wb_dest_reg_q;
   logic [31:0] wb_data_q;
   logic        fault_q;
   logic [1:0]  fault_code_q;

   logic        op_mem;
   logic        op_illegal;
   logic        op_misaligned;

   always_comb begin
      op_mem        = bus.ex_is_load | bus.ex_is_store;
      op_illegal    = bus.ex_is_load & bus.ex_is_store;
      op_misaligned = (bus.ex_addr[1:0] != 2'b00);
   end

   // The stage only takes new work while idle.
   assign bus.ex_ready = (state_q == IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         data_addr_q   <= '0;
         data_out_q    <= '0;
         data_read_q   <= 1'b0;
         data_write_q  <= 1'b0;
         wb_valid_q    <= 1'b0;
         wb_we_q       <= 1'b0;
         wb_dest_reg_q <= '0;
         wb_data_q     <= '0;
         fault_q       <= 1'b0;
         fault_code_q  <= '0;
      end else begin
         // Writeback and fault are single-cycle pulses by default.
         wb_valid_q <= 1'b0;
         fault_q    <= 1'b0;

         unique case (state_q)
            IDLE: begin
               if (bus.ex_valid) begin
                  wb_dest_reg_q <= bus.ex_dest_reg;
                  if (!op_mem) begin
                     wb_valid_q <= 1'b1;
                     wb_we_q    <= 1'b1;
                     wb_data_q  <= bus.ex_addr;
                  end else if (op_illegal) begin
                     // Illegal takes priority over the alignment check.
                     wb_valid_q   <= 1'b1;
                     wb_we_q      <= 1'b0;
                     fault_q      <= 1'b1;
                     fault_code_q <= CODE_ILLEGAL;
                  end else if (op_misaligned) begin
                     wb_valid_q   <= 1'b1;
                     wb_we_q      <= 1'b0;
                     fault_q      <= 1'b1;
                     fault_code_q <= CODE_MISALIGN;
                  end else begin
                     data_addr_q  <= bus.ex_addr;
                     data_out_q   <= bus.ex_store_data;
                     data_read_q  <= bus.ex_is_load;
                     data_write_q <= bus.ex_is_store;
                     cnt_q        <= '0;
                     state_q      <= ACCESS;
                  end
               end
            end

            ACCESS: begin
               if (bus.mem_ack) begin
                  // An ack in the timeout cycle still completes normally.
                  data_read_q  <= 1'b0;
                  data_write_q <= 1'b0;
                  wb_valid_q   <= 1'b1;
                  wb_we_q      <= data_read_q;
                  if (data_read_q) begin
                     wb_data_q <= bus.data_in;
                  end
                  state_q      <= RESP;
               end else if (cnt_q == CNT_LAST) begin
                  data_read_q  <= 1'b0;
                  data_write_q <= 1'b0;
                  wb_valid_q   <= 1'b1;
                  wb_we_q      <= 1'b0;
                  fault_q      <= 1'b1;
                  fault_code_q <= CODE_TIMEOUT;
                  state_q      <= RESP;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end

            RESP: begin
               state_q <= IDLE;
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.data_addr   = data_addr_q;
   assign bus.data_out    = data_out_q;
   assign bus.data_read   = data_read_q;
   assign bus.data_write  = data_write_q;
   assign bus.wb_valid    = wb_valid_q;
   assign bus.wb_we       = wb_we_q;
   assign bus.wb_dest_reg = wb_dest_reg_q;
   assign bus.wb_data     = wb_data_q;
   assign bus.fault       = fault_q;
   assign bus.fault_code  = fault_code_q;

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access -- directed and randomized checks of mem_access against a
// per-operation outcome model (latency, strobe cycles, writeback, fault).
module tb_mem_access;

   localparam int unsigned TMO = 16;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   mem_access_if bus ();

   mem_access #(.TIMEOUT(TMO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Memory side: inside an access, ack only in the chosen cycle with the
   // read data; outside, throw random acks and data that must be ignored.
   task automatic drive_mem(input bit in_access, input int unsigned k,
                            input int unsigned ack_at, input logic [31:0] rdata);
      if (in_access) begin
         bus.mem_ack = (k == ack_at);
         bus.data_in = (k == ack_at) ? rdata : $urandom;
      end else begin
         bus.mem_ack = 1'($urandom);
         bus.data_in = $urandom;
      end
   endtask

   task automatic junk_ex();
      bus.ex_valid      = 1'b0;
      bus.ex_is_load    = 1'($urandom);
      bus.ex_is_store   = 1'($urandom);
      bus.ex_addr       = $urandom;
      bus.ex_store_data = $urandom;
      bus.ex_dest_reg   = 4'($urandom);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_data_addr"},   bus.data_addr, 32'd0);
      chk({tag, "_data_out"},    bus.data_out, 32'd0);
      chk({tag, "_data_read"},   32'(bus.data_read), 32'd0);
      chk({tag, "_data_write"},  32'(bus.data_write), 32'd0);
      chk({tag, "_wb_valid"},    32'(bus.wb_valid), 32'd0);
      chk({tag, "_wb_we"},       32'(bus.wb_we), 32'd0);
      chk({tag, "_wb_dest_reg"}, 32'(bus.wb_dest_reg), 32'd0);
      chk({tag, "_wb_data"},     bus.wb_data, 32'd0);
      chk({tag, "_fault"},       32'(bus.fault), 32'd0);
      chk({tag, "_fault_code"},  32'(bus.fault_code), 32'd0);
   endtask

   // ack_at: ACCESS cycle (1-based) in which mem_ack is given; 0 = never.
   task automatic run_op(input string tag, input bit ld, input bit st,
                         input logic [31:0] addr, input logic [31:0] sd,
                         input logic [3:0] dest, input int unsigned ack_at,
                         input logic [31:0] rdata, input bit gap);
      bit          exp_we, exp_fault, done;
      logic [1:0]  exp_code;
      logic [31:0] exp_data;
      int unsigned exp_strobes, exp_lat, cyc, strobes, w;

      // Outcome model: what the operation must produce, from its type.
      exp_code = 2'd0;
      exp_data = 32'd0;
      if (!(ld || st)) begin
         exp_we = 1; exp_fault = 0; exp_data = addr; exp_strobes = 0; exp_lat = 1;
      end else if (ld && st) begin
         exp_we = 0; exp_fault = 1; exp_code = 2'd2; exp_strobes = 0; exp_lat = 1;
      end else if (addr % 4 != 0) begin
         exp_we = 0; exp_fault = 1; exp_code = 2'd1; exp_strobes = 0; exp_lat = 1;
      end else if (ack_at >= 1 && ack_at <= TMO) begin
         exp_we = ld; exp_fault = 0; exp_data = rdata;
         exp_strobes = ack_at; exp_lat = ack_at + 1;
      end else begin
         exp_we = 0; exp_fault = 1; exp_code = 2'd3; exp_strobes = TMO; exp_lat = TMO + 1;
      end

      w = 0;
      while (bus.ex_ready !== 1'b1 && w < 50) begin
         drive_mem(0, 0, 0, 0);
         tick();
         w++;
      end
      chk({tag, "_ready_before_accept"}, 32'(bus.ex_ready), 32'd1);

      bus.ex_valid      = 1'b1;
      bus.ex_is_load    = ld;
      bus.ex_is_store   = st;
      bus.ex_addr       = addr;
      bus.ex_store_data = sd;
      bus.ex_dest_reg   = dest;
      drive_mem(0, 0, 0, 0);

      cyc = 0;
      strobes = 0;
      done = 0;
      while (!done && cyc < TMO + 10) begin
         tick();
         cyc++;
         junk_ex();
         if (bus.data_read || bus.data_write) begin
            strobes++;
            chk({tag, "_strobe_excl"}, 32'(bus.data_read & bus.data_write), 32'd0);
            chk({tag, "_strobe_kind"}, 32'({bus.data_read, bus.data_write}), 32'({ld, st}));
            chk({tag, "_data_addr"}, bus.data_addr, addr);
            if (st) chk({tag, "_data_out"}, bus.data_out, sd);
            drive_mem(1, strobes, ack_at, rdata);
         end else begin
            drive_mem(0, 0, 0, 0);
         end
         if (bus.wb_valid === 1'b1) begin
            done = 1;
            chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
            chk({tag, "_strobe_cycles"}, 32'(strobes), 32'(exp_strobes));
            chk({tag, "_wb_we"}, 32'(bus.wb_we), 32'(exp_we));
            if (exp_we) begin
               chk({tag, "_wb_dest"}, 32'(bus.wb_dest_reg), 32'(dest));
               chk({tag, "_wb_data"}, bus.wb_data, exp_data);
            end
            chk({tag, "_fault"}, 32'(bus.fault), 32'(exp_fault));
            if (exp_fault) chk({tag, "_fault_code"}, 32'(bus.fault_code), 32'(exp_code));
            chk({tag, "_ready_at_wb"}, 32'(bus.ex_ready), 32'(exp_strobes == 0));
         end else begin
            chk({tag, "_ready_busy"}, 32'(bus.ex_ready), 32'd0);
            chk({tag, "_fault_early"}, 32'(bus.fault), 32'd0);
         end
      end
      chk({tag, "_wb_seen"}, 32'(done), 32'd1);

      if (gap) begin
         tick();
         drive_mem(0, 0, 0, 0);
         chk({tag, "_wb_pulse"}, 32'(bus.wb_valid), 32'd0);
         chk({tag, "_fault_pulse"}, 32'(bus.fault), 32'd0);
         chk({tag, "_ready_after"}, 32'(bus.ex_ready), 32'd1);
         chk({tag, "_strobe_after"}, 32'({bus.data_read, bus.data_write}), 32'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ld, st;
      logic [31:0] a;
      int unsigned kind, ack;

      // Reset state
      reset = 1'b1;
      junk_ex();
      bus.mem_ack = 1'b0;
      bus.data_in = '0;
      tick();
      tick();
      chk_all_zero("reset");
      reset = 1'b0;
      tick();
      chk("ready_after_reset", 32'(bus.ex_ready), 32'd1);

      // Load with ack in the 3rd access cycle
      run_op("load3", 1, 0, 32'h100, 32'h0, 4'd3, 3, 32'hDEADBEEF, 1);
      // Store with immediate ack
      run_op("store1", 0, 1, 32'h204, 32'h12345678, 4'd5, 1, 32'h0, 1);
      // Misaligned load and illegal op
      run_op("misalign", 1, 0, 32'h103, 32'h0, 4'd7, 1, 32'h0, 1);
      run_op("illegal", 1, 1, 32'h200, 32'h0, 4'd8, 1, 32'h0, 1);
      // Timeout, then a normal op right after
      run_op("timeout", 1, 0, 32'h400, 32'h0, 4'd9, 0, 32'h0, 0);
      run_op("after_tmo", 0, 1, 32'h408, 32'hCAFEF00D, 4'd1, 2, 32'h0, 1);
      // Ack in the timeout cycle wins
      run_op("ack_at_tmo", 1, 0, 32'h40C, 32'h0, 4'd6, TMO, 32'hA5A5A5A5, 1);
      // Back-to-back ALU result then load
      run_op("alu55", 0, 0, 32'h55, 32'h0, 4'd2, 0, 32'h0, 0);
      run_op("b2b_load", 1, 0, 32'h80, 32'h0, 4'd4, 1, 32'h0BADF00D, 1);

      // Reset during the 2nd access cycle
      bus.ex_valid = 1'b1; bus.ex_is_load = 1'b1; bus.ex_is_store = 1'b0;
      bus.ex_addr = 32'h300; bus.ex_dest_reg = 4'd11; bus.mem_ack = 1'b0;
      tick();
      junk_ex();
      chk("rst_acc1_read", 32'(bus.data_read), 32'd1);
      tick();
      chk("rst_acc2_read", 32'(bus.data_read), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk_all_zero("rst_mid");
      chk("rst_mid_ready", 32'(bus.ex_ready), 32'd1);
      bus.mem_ack = 1'b1;
      bus.data_in = 32'hFFFFFFFF;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("late_ack_read", 32'(bus.data_read), 32'd0);
         chk("late_ack_wb", 32'(bus.wb_valid), 32'd0);
      end
      bus.mem_ack = 1'b0;
      run_op("post_rst", 1, 0, 32'h304, 32'h0, 4'd12, 2, 32'h13579BDF, 1);

      // Randomized operations
      for (int n = 0; n < 40; n++) begin
         kind = $urandom_range(0, 5);
         ld = (kind == 1 || kind == 2 || kind == 5);
         st = (kind == 3 || kind == 4 || kind == 5);
         a = $urandom;
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         ack = $urandom_range(0, TMO + 2);
         run_op("rand", ld, st, a, $urandom, 4'($urandom), ack, $urandom,
                1'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
REQ-004 ex_valid  input  1  execute stage presents an operation this cycle.
REQ-005 ex_ready  output  1  stage can accept an operation this cycle; upstream stalls while low.
REQ-006 ex_is_load / ex_is_store  input  1 each  memory operation type.
REQ-007 ex_addr  input  32  ALU result: effective address, or the result value for non-memory operations.
REQ-008 ex_store_data  input  32  store value.
REQ-009 ex_dest_reg  input  4  writeback destination.
REQ-010 data_addr, data_out  output  32 each  data memory address and write data.
REQ-011 data_read, data_write  output  1 each  memory request strobes.
REQ-012 data_in  input  32  read data.
REQ-013 mem_ack  input  1  memory completion; data_in is valid in the same cycle as mem_ack.
REQ-014 wb_valid, wb_we  output  1 each  writeback strobe and register-write enable.
REQ-015 wb_dest_reg  output  4  writeback destination.
REQ-016 wb_data  output  32  writeback data.
REQ-017 fault  output  1  one-cycle pulse on an error.
REQ-018 fault_code  output  2  error cause: 01 misaligned, 10 illegal (load and store both set), 11 timeout.
REQ-019 Parameter TIMEOUT, default 16: the number of access cycles without mem_ack before an abort.

Function
REQ-020 The FSM SHALL have three states: IDLE, ACCESS, RESP.
REQ-021 ex_ready SHALL equal (state==IDLE), driven combinationally from state.
REQ-022 An operation SHALL be accepted when ex_valid && ex_ready.
REQ-023 Non-memory operation accepted: the next cycle SHALL give wb_valid=1, wb_we=1, wb_data=ex_addr, with state staying IDLE.
REQ-024 Load/store accepted with ex_addr[1:0]==0: the stage SHALL latch addr, data and dest, then enter ACCESS.
REQ-025 In ACCESS: data_read (load) or data_write (store) SHALL be 1, and data_addr/data_out SHALL hold stable until mem_ack.
REQ-026 mem_ack in ACCESS SHALL move the FSM to RESP and deassert the strobe the next cycle; a load SHALL capture data_in at the ack edge.
REQ-027 RESP SHALL last one cycle, with wb_valid=1; wb_we=1 and wb_data=captured data for a load; wb_we=0 for a store. The FSM then returns to IDLE.
REQ-028 Minimum load/store latency: acceptance to wb_valid SHALL be 2 cycles when mem_ack arrives in the first ACCESS cycle.
REQ-029 A 4-bit counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without mem_ack.
REQ-030 Timeout: if the count reaches TIMEOUT-1 without mem_ack, the stage SHALL drop the strobes, enter RESP with wb_we=0, and pulse fault with code 11.
REQ-031 If mem_ack arrives in the same cycle as the timeout, the ack SHALL win and no fault is raised.
REQ-032 A misaligned load/store (ex_addr[1:0]!=0) SHALL cause no memory access: the next cycle gives wb_valid=1, wb_we=0, and a fault pulse with code 01.
REQ-033 ex_is_load && ex_is_store SHALL be illegal: no access, handled as in REQ-032 but with code 10.
REQ-034 mem_ack outside ACCESS SHALL be ignored.
REQ-035 data_read and data_write SHALL never be asserted together.
REQ-036 wb_valid and fault SHALL be single-cycle pulses per operation.

Reset
REQ-037 Reset SHALL force state=IDLE and counter=0.
REQ-038 Reset SHALL force every registered output to 0: data_addr, data_out, data_read, data_write, wb_valid, wb_we, wb_dest_reg, wb_data, fault, fault_code.
REQ-039 Reset asserted mid-ACCESS SHALL abort the access, with the strobes low the following cycle and no wb_valid.
REQ-040 ex_ready SHALL be 1 in the cycle after reset deasserts.

Verification
REQ-041 Load: addr 0x100, dest 3, data_in 0xDEADBEEF, ack in the 3rd ACCESS cycle -> data_read high for 3 cycles at 0x100; wb_valid/wb_we=1, wb_dest_reg=3, wb_data=0xDEADBEEF.
REQ-042 Store: addr 0x204, data 0x12345678, immediate ack -> data_write for 1 cycle with data_out=0x12345678; wb_valid=1, wb_we=0; ex_ready low for 2 cycles.
REQ-043 Misaligned load at 0x103 -> data_read never asserted; fault=1, fault_code=01, wb_we=0.
REQ-044 No ack for 16 cycles -> strobe drops after 16 cycles; fault_code=11; the next operation is accepted normally.
REQ-045 Back-to-back: ALU result 0x55 (dest 2) then load -> wb 0x55 the next cycle, then the load proceeds with no lost operation.
REQ-046 Reset in the 2nd ACCESS cycle -> all outputs 0 the next cycle; a late mem_ack is ignored.
